// File: rtl/fv_ccp_tagpipe_pkg.sv
// Shared widths, derived-width helpers and the address decode used by the CCP tag-pipe index stage.
package fv_ccp_tagpipe_pkg;

    // Fixed working widths for the generic decode; module parameters are widened to these.
    localparam int unsigned MaxAddrW = 64;
    localparam int unsigned MaxBnkW  = 4;
    localparam int unsigned PosW     = 8;
    localparam int unsigned PosExtW  = MaxBnkW * PosW;
    localparam int unsigned MaskExtW = MaxBnkW * MaxAddrW;

    typedef struct packed {
        logic [MaxBnkW-1:0]  bank;
        logic [MaxAddrW-1:0] set;
        logic [MaxAddrW-1:0] tag;
    } decode_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // Bank output width: at least one bit even for a single bank.
    function automatic int unsigned bnk_w(input int unsigned n_banks);
        return (n_banks > 1) ? $clog2(n_banks) : 1;
    endfunction

    function automatic int unsigned set_w(input int unsigned n_sets, input int unsigned n_banks);
        return $clog2(n_sets) - $clog2(n_banks);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned off_w,
                                          input int unsigned n_sets);
        return addr_w - off_w - $clog2(n_sets);
    endfunction

    // Legal parameter set: power-of-2 sizes, bank positions inside the index and strictly ascending.
    function automatic bit params_ok(input int unsigned addr_w, input int unsigned off_w,
                                     input int unsigned n_sets, input int unsigned n_banks,
                                     input logic [PosExtW-1:0] sel_pos);
        bit ok;
        int unsigned idx_w;
        int unsigned nb;
        int unsigned pos;
        int unsigned prev;
        ok = is_pow2(n_sets) && is_pow2(n_banks) && (n_banks <= 16) && (n_sets > n_banks) &&
             (addr_w <= MaxAddrW) && (off_w + $clog2(n_sets) < addr_w);
        idx_w = $clog2(n_sets);
        nb = $clog2(n_banks);
        prev = 0;
        for (int unsigned b = 0; b < MaxBnkW; b++) begin
            if (b < nb) begin
                pos = 32'(sel_pos[b*PosW +: PosW]);
                if (pos >= idx_w) ok = 1'b0;
                if (b > 0 && pos <= prev) ok = 1'b0;
                prev = pos;
            end
        end
        return ok;
    endfunction

    // Split an address into bank (selected index bits, optionally hashed), packed set and tag.
    function automatic decode_t decode_addr(input logic [MaxAddrW-1:0] addr,
                                            input int unsigned off_w,
                                            input int unsigned idx_w,
                                            input int unsigned n_bank_bits,
                                            input logic [PosExtW-1:0] sel_pos,
                                            input logic [MaskExtW-1:0] hash_mask);
        decode_t d;
        logic [MaxAddrW-1:0] idx;
        logic [MaxAddrW-1:0] sh;
        logic [MaxBnkW-1:0] bit_b;
        int unsigned j;
        logic taken;
        d = '0;
        idx = addr >> off_w;
        j = 0;
        for (int unsigned b = 0; b < MaxBnkW; b++) begin
            if (b < n_bank_bits) begin
                sh = idx >> sel_pos[b*PosW +: PosW];
                bit_b = MaxBnkW'(sh[0] ^ (^(addr & hash_mask[b*MaxAddrW +: MaxAddrW])));
                d.bank = d.bank | (bit_b << b);
            end
        end
        // Remaining index bits are packed low-to-high into the set.
        for (int unsigned i = 0; i < MaxAddrW; i++) begin
            taken = 1'b0;
            for (int unsigned b = 0; b < MaxBnkW; b++) begin
                if (b < n_bank_bits && 32'(sel_pos[b*PosW +: PosW]) == i) taken = 1'b1;
            end
            if (i < idx_w && !taken) begin
                sh = idx >> i;
                d.set = d.set | ((sh & MaxAddrW'(1)) << j);
                j++;
            end
        end
        // Caller zero-extends addr, so everything above the index is exactly the tag.
        d.tag = addr >> (off_w + idx_w);
        return d;
    endfunction

endpackage

// File: rtl/fv_ccp_tagpipe_addr_decode.sv
// Combinational address decode: bank / set-within-bank / tag.
module fv_ccp_tagpipe_addr_decode import fv_ccp_tagpipe_pkg::*; #(
    parameter int unsigned ADDRESS_W           = 32,
    parameter int unsigned CACHE_LINE_OFFSET_W = 6,
    parameter int unsigned N_SETS              = 1024,
    parameter int unsigned N_TAG_BANKS         = 4,
    parameter logic [bnk_w(N_TAG_BANKS)*PosW-1:0]      BANK_SEL_POS   = {8'd1, 8'd0},
    parameter logic [bnk_w(N_TAG_BANKS)*ADDRESS_W-1:0] BANK_HASH_MASK = '0,
    localparam int unsigned BNK_W = bnk_w(N_TAG_BANKS),
    localparam int unsigned SET_W = set_w(N_SETS, N_TAG_BANKS),
    localparam int unsigned TAG_W = tag_w(ADDRESS_W, CACHE_LINE_OFFSET_W, N_SETS)
) (
    input  logic [ADDRESS_W-1:0] addr_i,
    output logic [BNK_W-1:0]     bank_o,
    output logic [SET_W-1:0]     set_o,
    output logic [TAG_W-1:0]     tag_o
);

    localparam int unsigned IDX_W = $clog2(N_SETS);
    localparam int unsigned NB    = $clog2(N_TAG_BANKS);
    localparam logic [PosExtW-1:0] SelPosExt = PosExtW'(BANK_SEL_POS);

    logic [MaxAddrW-1:0] addr_ext;
    logic [MaskExtW-1:0] mask_ext;
    decode_t             dec;
    logic                unused_dec_bits;

    // Widen the address and per-bank hash masks to the package's fixed layout, then decode.
    always_comb begin
        addr_ext = '0;
        addr_ext[ADDRESS_W-1:0] = addr_i;
        mask_ext = '0;
        for (int b = 0; b < BNK_W; b++) begin
            mask_ext[b*MaxAddrW +: ADDRESS_W] = BANK_HASH_MASK[b*ADDRESS_W +: ADDRESS_W];
        end
        dec = decode_addr(addr_ext, CACHE_LINE_OFFSET_W, IDX_W, NB, SelPosExt, mask_ext);
    end

    assign bank_o = dec.bank[BNK_W-1:0];
    assign set_o  = dec.set[SET_W-1:0];
    assign tag_o  = dec.tag[TAG_W-1:0];

    // High bits of the wide decode are always zero for this configuration.
    assign unused_dec_bits = ^dec;

endmodule

// File: rtl/fv_ccp_tagpipe_index_pipe.sv
// Two-stage valid/ready tag-pipe index decomposer with per-bank counters and same-set detection.
module fv_ccp_tagpipe_index_pipe import fv_ccp_tagpipe_pkg::*; #(
    parameter int unsigned ADDRESS_W           = 32,
    parameter int unsigned CACHE_LINE_OFFSET_W = 6,
    parameter int unsigned N_SETS              = 1024,
    parameter int unsigned N_TAG_BANKS         = 4,
    parameter logic [bnk_w(N_TAG_BANKS)*PosW-1:0]      BANK_SEL_POS   = {8'd1, 8'd0},
    parameter logic [bnk_w(N_TAG_BANKS)*ADDRESS_W-1:0] BANK_HASH_MASK = '0,
    parameter int unsigned CNT_W               = 16,
    localparam int unsigned BNK_W          = bnk_w(N_TAG_BANKS),
    localparam int unsigned SET_PER_BANK_W = set_w(N_SETS, N_TAG_BANKS),
    localparam int unsigned TAG_W          = tag_w(ADDRESS_W, CACHE_LINE_OFFSET_W, N_SETS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDRESS_W-1:0]         in_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BNK_W-1:0]             out_bank,
    output logic [SET_PER_BANK_W-1:0]    out_set,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_conflict,
    input  logic                         cnt_clr,
    output logic [N_TAG_BANKS*CNT_W-1:0] bank_cnt
);

    if (!params_ok(ADDRESS_W, CACHE_LINE_OFFSET_W, N_SETS, N_TAG_BANKS,
                   PosExtW'(BANK_SEL_POS))) begin : gen_bad_params
        $error("fv_ccp_tagpipe_index_pipe: illegal N_SETS/N_TAG_BANKS/BANK_SEL_POS");
    end

    logic                      s1_v_q, s1_v_d;
    logic [ADDRESS_W-1:0]      s1_addr_q, s1_addr_d;
    logic                      s2_v_q, s2_v_d;
    logic [BNK_W-1:0]          s2_bank_q, s2_bank_d;
    logic [SET_PER_BANK_W-1:0] s2_set_q, s2_set_d;
    logic [TAG_W-1:0]          s2_tag_q, s2_tag_d;
    logic                      last_v_q, last_v_d;
    logic [BNK_W-1:0]          last_bank_q, last_bank_d;
    logic [SET_PER_BANK_W-1:0] last_set_q, last_set_d;
    logic [N_TAG_BANKS-1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic [BNK_W-1:0]          dec_bank;
    logic [SET_PER_BANK_W-1:0] dec_set;
    logic [TAG_W-1:0]          dec_tag;
    logic                      s2_take, s1_take, in_fire, out_fire;

    fv_ccp_tagpipe_addr_decode #(
        .ADDRESS_W           (ADDRESS_W),
        .CACHE_LINE_OFFSET_W (CACHE_LINE_OFFSET_W),
        .N_SETS              (N_SETS),
        .N_TAG_BANKS         (N_TAG_BANKS),
        .BANK_SEL_POS        (BANK_SEL_POS),
        .BANK_HASH_MASK      (BANK_HASH_MASK)
    ) u_decode (
        .addr_i (s1_addr_q),
        .bank_o (dec_bank),
        .set_o  (dec_set),
        .tag_o  (dec_tag)
    );

    // A stage may load when its successor is empty or handing off this cycle.
    assign out_fire = s2_v_q & out_ready;
    assign s2_take  = ~s2_v_q | out_ready;
    assign s1_take  = ~s1_v_q | s2_take;
    assign in_ready = s1_take;
    assign in_fire  = in_valid & s1_take;

    // Next state for pipeline stages and the last-handed-off tracker.
    always_comb begin
        s1_v_d      = s1_v_q;
        s1_addr_d   = s1_addr_q;
        s2_v_d      = s2_v_q;
        s2_bank_d   = s2_bank_q;
        s2_set_d    = s2_set_q;
        s2_tag_d    = s2_tag_q;
        last_v_d    = last_v_q;
        last_bank_d = last_bank_q;
        last_set_d  = last_set_q;
        if (s1_take) begin
            s1_v_d = in_valid;
            if (in_fire) s1_addr_d = in_addr;
        end
        if (s2_take) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_bank_d = dec_bank;
                s2_set_d  = dec_set;
                s2_tag_d  = dec_tag;
            end
        end
        if (out_fire) begin
            last_v_d    = 1'b1;
            last_bank_d = s2_bank_q;
            last_set_d  = s2_set_q;
        end
    end

    // Saturating per-bank handoff counters; a clear wins over a coincident handoff.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_fire) begin
            for (int k = 0; k < N_TAG_BANKS; k++) begin
                if (BNK_W'(k) == s2_bank_q && cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q      <= 1'b0;
            s1_addr_q   <= '0;
            s2_v_q      <= 1'b0;
            s2_bank_q   <= '0;
            s2_set_q    <= '0;
            s2_tag_q    <= '0;
            last_v_q    <= 1'b0;
            last_bank_q <= '0;
            last_set_q  <= '0;
            cnt_q       <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_addr_q   <= s1_addr_d;
            s2_v_q      <= s2_v_d;
            s2_bank_q   <= s2_bank_d;
            s2_set_q    <= s2_set_d;
            s2_tag_q    <= s2_tag_d;
            last_v_q    <= last_v_d;
            last_bank_q <= last_bank_d;
            last_set_q  <= last_set_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid    = s2_v_q;
    assign out_bank     = s2_bank_q;
    assign out_set      = s2_set_q;
    assign out_tag      = s2_tag_q;
    assign out_conflict = s2_v_q & last_v_q & (s2_bank_q == last_bank_q) & (s2_set_q == last_set_q);
    assign bank_cnt     = cnt_q;

endmodule

// File: tb/tb_fv_ccp_tagpipe_index_pipe.sv
// Directed bench: four configurations share one stimulus stream.
//   a: defaults, b: hash mask on bank bit 0, c: CNT_W=4, d: single bank.
module tb_fv_ccp_tagpipe_index_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, out_ready, cnt_clr;
    logic [31:0] in_addr;

    logic a_in_ready, a_out_valid, a_conf;
    logic [1:0] a_bank; logic [7:0] a_set; logic [15:0] a_tag; logic [63:0] a_cnt;
    logic b_in_ready, b_out_valid, b_conf;
    logic [1:0] b_bank; logic [7:0] b_set; logic [15:0] b_tag; logic [63:0] b_cnt;
    logic c_in_ready, c_out_valid, c_conf;
    logic [1:0] c_bank; logic [7:0] c_set; logic [15:0] c_tag; logic [15:0] c_cnt;
    logic d_in_ready, d_out_valid, d_conf;
    logic [0:0] d_bank; logic [9:0] d_set; logic [15:0] d_tag; logic [15:0] d_cnt;

    fv_ccp_tagpipe_index_pipe u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .in_addr(in_addr),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_bank(a_bank), .out_set(a_set),
        .out_tag(a_tag), .out_conflict(a_conf), .cnt_clr(cnt_clr), .bank_cnt(a_cnt)
    );

    fv_ccp_tagpipe_index_pipe #(.BANK_HASH_MASK({32'h0, 32'h0001_0000})) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready), .in_addr(in_addr),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_bank(b_bank), .out_set(b_set),
        .out_tag(b_tag), .out_conflict(b_conf), .cnt_clr(cnt_clr), .bank_cnt(b_cnt)
    );

    fv_ccp_tagpipe_index_pipe #(.CNT_W(4)) u_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready), .in_addr(in_addr),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_bank(c_bank), .out_set(c_set),
        .out_tag(c_tag), .out_conflict(c_conf), .cnt_clr(cnt_clr), .bank_cnt(c_cnt)
    );

    fv_ccp_tagpipe_index_pipe #(.N_TAG_BANKS(1), .BANK_SEL_POS(8'd0)) u_d (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d_in_ready), .in_addr(in_addr),
        .out_valid(d_out_valid), .out_ready(out_ready), .out_bank(d_bank), .out_set(d_set),
        .out_tag(d_tag), .out_conflict(d_conf), .cnt_clr(cnt_clr), .bank_cnt(d_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  a_bank;
        logic [7:0]  a_set;
        logic [15:0] a_tag;
        logic        a_conf;
        logic [1:0]  b_bank;
        logic [9:0]  d_set;
        logic        d_conf;
    } vec_t;

    vec_t        tbl[7];
    int          exp_cnt[4];
    logic [31:0] bp[4];
    int          nacc;
    int          k;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{32'h0001_2345, 2'd1, 8'h23, 16'h0001, 1'b0, 2'd0, 10'h08D, 1'b0};
        tbl[1] = '{32'h0002_2345, 2'd1, 8'h23, 16'h0002, 1'b1, 2'd1, 10'h08D, 1'b1};
        tbl[2] = '{32'h0001_2385, 2'd2, 8'h23, 16'h0001, 1'b0, 2'd3, 10'h08E, 1'b0};
        tbl[3] = '{32'h0000_0000, 2'd0, 8'h00, 16'h0000, 1'b0, 2'd0, 10'h000, 1'b0};
        tbl[4] = '{32'h0000_0040, 2'd1, 8'h00, 16'h0000, 1'b0, 2'd1, 10'h001, 1'b0};
        tbl[5] = '{32'hFFFF_FFC0, 2'd3, 8'hFF, 16'hFFFF, 1'b0, 2'd2, 10'h3FF, 1'b0};
        tbl[6] = '{32'hFFFF_FFC0, 2'd3, 8'hFF, 16'hFFFF, 1'b1, 2'd2, 10'h3FF, 1'b1};
        bp[0] = 32'h0010_0000; bp[1] = 32'h0020_0000;
        bp[2] = 32'h0030_0000; bp[3] = 32'h0040_0000;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

        reset = 1'b1; in_valid = 1'b0; in_addr = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset out_valid", 64'(a_out_valid), 64'd0);
        chk("reset in_ready", 64'(a_in_ready), 64'd1);
        chk("reset conflict", 64'(a_conf), 64'd0);
        chk("reset bank/set/tag", 64'({a_bank, a_set, a_tag}), 64'd0);
        chk("reset bank_cnt", a_cnt, 64'd0);
        chk("reset d bank_cnt", 64'(d_cnt), 64'd0);

        // Table: one request at a time, check decode then the counter after handoff.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_addr = tbl[i].addr;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d out_valid", i), 64'(a_out_valid), 64'd1);
            chk($sformatf("v%0d bank", i), 64'(a_bank), 64'(tbl[i].a_bank));
            chk($sformatf("v%0d set", i), 64'(a_set), 64'(tbl[i].a_set));
            chk($sformatf("v%0d tag", i), 64'(a_tag), 64'(tbl[i].a_tag));
            chk($sformatf("v%0d conflict", i), 64'(a_conf), 64'(tbl[i].a_conf));
            chk($sformatf("v%0d hash bank", i), 64'(b_bank), 64'(tbl[i].b_bank));
            chk($sformatf("v%0d 1bank bank", i), 64'(d_bank), 64'd0);
            chk($sformatf("v%0d 1bank set", i), 64'(d_set), 64'(tbl[i].d_set));
            chk($sformatf("v%0d 1bank conflict", i), 64'(d_conf), 64'(tbl[i].d_conf));
            k = int'(tbl[i].a_bank);
            exp_cnt[k]++;
            @(negedge clk);
            chk($sformatf("v%0d bank_cnt", i), 64'(a_cnt[k*16 +: 16]), 64'(exp_cnt[k]));
            chk($sformatf("v%0d drained", i), 64'(a_out_valid), 64'd0);
        end
        chk("table bank_cnt all", a_cnt, {16'd2, 16'd1, 16'd3, 16'd1});

        // Backpressure: offer 4 requests over 5 stalled cycles; only 2 fit.
        out_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("bp c%0d in_ready", c), 64'(a_in_ready), 64'd0);
                chk($sformatf("bp c%0d out_valid", c), 64'(a_out_valid), 64'd1);
                chk($sformatf("bp c%0d held tag", c), 64'(a_tag), 64'h0010);
                chk($sformatf("bp c%0d held bank/set", c), 64'({a_bank, a_set}), 64'd0);
            end
            in_valid = 1'b1;
            in_addr  = bp[(nacc > 3) ? 3 : nacc];
            if (a_in_ready) nacc++;
        end
        @(negedge clk);
        chk("bp accepted", 64'(nacc), 64'd2);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("drain0 valid", 64'(a_out_valid), 64'd1);
        chk("drain0 tag", 64'(a_tag), 64'h0010);
        @(negedge clk);
        chk("drain1 valid", 64'(a_out_valid), 64'd1);
        chk("drain1 tag", 64'(a_tag), 64'h0020);
        chk("drain1 conflict", 64'(a_conf), 64'd1);
        @(negedge clk);
        chk("drain empty", 64'(a_out_valid), 64'd0);

        // Saturation: 20 streamed handoffs to bank 0.
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1; in_addr = '0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat c bank0", 64'(c_cnt[3:0]), 64'd15);
        chk("nosat a bank0", 64'(a_cnt[15:0]), 64'd23);

        // cnt_clr coincident with a handoff: counters end at 0, last_* unaffected.
        in_valid = 1'b1; in_addr = '0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr handoff valid", 64'(a_out_valid), 64'd1);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr a bank_cnt", a_cnt, 64'd0);
        chk("clr c bank_cnt", 64'(c_cnt), 64'd0);
        in_valid = 1'b1; in_addr = '0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr keeps last", 64'(a_conf), 64'd1);
        @(negedge clk);
        chk("count after clr", 64'(a_cnt[15:0]), 64'd1);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid = 1'b1; in_addr = 32'h0001_2345;
        @(negedge clk);
        in_addr = 32'h0002_2345;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full in_ready", 64'(a_in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst full out_valid", 64'(a_out_valid), 64'd0);
        chk("rst full in_ready", 64'(a_in_ready), 64'd1);
        chk("rst full bank_cnt", a_cnt, 64'd0);
        chk("rst full outputs", 64'({a_bank, a_set, a_tag, a_conf}), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst no stale c%0d", c), 64'(a_out_valid), 64'd0);
        end
        in_valid = 1'b1; in_addr = 32'h0001_2345;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("post rst valid", 64'(a_out_valid), 64'd1);
        chk("post rst bank", 64'(a_bank), 64'd1);
        chk("post rst conflict", 64'(a_conf), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
